// File: rtl/regfile_param.sv
// ---------------------------------------------------------------------------
// regfile_param
//   Parameterised register file with two combinational read ports, one
//   synchronous write port, optional same-cycle write-to-read forwarding and
//   a sequential clear engine that zeroes one register per clock.
//
// Parameters
//   DATA_W   : register / data port width
//   NUM_REGS : number of implemented registers (2 .. 2**ADDR_W)
//   ADDR_W   : width of every address port
//   BYPASS   : 1 = forward WriteData to a read port addressing WriteReg
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   rst       : asynchronous active-low reset
//   A1, A2    : read addresses
//   R1, R2    : read data (combinational, zero for unimplemented addresses)
//   RegWrite  : write enable (dropped while Busy)
//   WriteReg  : write address (ignored when >= NUM_REGS)
//   WriteData : write data
//   ClrReq    : start a clear sequence (sampled only in IDLE)
//   Busy      : clear sequence in progress (CLEAR or DONE)
//   ClrDone   : one-cycle pulse in the DONE state
// ---------------------------------------------------------------------------
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] R1,
    output logic [DATA_W-1:0] R2,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              ClrReq,
    output logic              Busy,
    output logic              ClrDone
);

    // Wide enough to hold NUM_REGS-1; the counter never moves past it.
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] regs [NUM_REGS];

    logic              wr_en;
    logic              byp1;
    logic              byp2;

    // The extra leading zero keeps the compare exact when NUM_REGS == 2**ADDR_W.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < (ADDR_W + 1)'(NUM_REGS);
    endfunction

    // Writes are only accepted while idle, which also disables forwarding
    // during a clear sequence.
    assign wr_en = RegWrite && (state == S_IDLE) && in_range(WriteReg);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (ClrReq) state_nxt = S_CLEAR;
            S_CLEAR: if (idx == LAST_IDX) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Index is parked at 0 whenever idle, so a new clear always starts at reg 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
        end else if (state != S_CLEAR) begin
            idx <= '0;
        end else if (idx != LAST_IDX) begin
            idx <= idx + 1'b1;
        end
    end

    // ---------------- storage ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (state == S_CLEAR) begin
            regs[idx] <= '0;
        end else if (wr_en) begin
            regs[WriteReg] <= WriteData;
        end
    end

    // ---------------- read ports ----------------
    assign byp1 = (BYPASS != 0) && wr_en && (A1 == WriteReg);
    assign byp2 = (BYPASS != 0) && wr_en && (A2 == WriteReg);

    assign R1 = byp1 ? WriteData : (in_range(A1) ? regs[A1] : '0);
    assign R2 = byp2 ? WriteData : (in_range(A2) ? regs[A2] : '0);

    assign Busy    = (state != S_IDLE);
    assign ClrDone = (state == S_DONE);

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 Parameter DATA_W, default 32, width of each register and data port.
REQ-002 Parameter NUM_REGS, default 16, number of implemented registers (2..2**ADDR_W).
REQ-003 Parameter ADDR_W, default 4, width of every address port.
REQ-004 Parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 A1  input  ADDR_W  read port 1 address.
REQ-008 A2  input  ADDR_W  read port 2 address.
REQ-009 R1  output  DATA_W  read port 1 data, combinational.
REQ-010 R2  output  DATA_W  read port 2 data, combinational.
REQ-011 RegWrite  input  1  write enable.
REQ-012 WriteReg  input  ADDR_W  write address.
REQ-013 WriteData  input  DATA_W  write data.
REQ-014 ClrReq  input  1  request sequential clear of all registers.
REQ-015 Busy  output  1  clear sequence in progress.
REQ-016 ClrDone  output  1  one-cycle pulse, clear sequence finished.

Function
REQ-017 Write: RegWrite=1, Busy=0, WriteReg<NUM_REGS -> register[WriteReg] <= WriteData at next rising edge.
REQ-018 Write with WriteReg>=NUM_REGS shall be ignored; no register changes.
REQ-019 Read: Rn = register[An] when An<NUM_REGS, else all zeros; zero-latency combinational path.
REQ-020 BYPASS=1: if RegWrite=1, Busy=0, WriteReg<NUM_REGS and An==WriteReg, Rn = WriteData in the same cycle; independently per port.
REQ-021 BYPASS=0: Rn returns the pre-write value during the write cycle, new value from the next cycle.
REQ-022 FSM states IDLE, CLEAR, DONE; encoding free.
REQ-023 IDLE: ClrReq=1 at rising edge -> CLEAR, index counter <= 0; otherwise stay IDLE.
REQ-024 CLEAR: each cycle register[index] <= 0, index <= index+1; on index==NUM_REGS-1 transition to DONE.
REQ-025 CLEAR takes exactly NUM_REGS cycles; DONE lasts exactly one cycle, then IDLE.
REQ-026 Busy = 1 in CLEAR and DONE, 0 in IDLE (Moore output).
REQ-027 ClrDone = 1 only in DONE.
REQ-028 RegWrite while Busy=1 shall be ignored (dropped, not queued); bypass disabled while Busy=1.
REQ-029 ClrReq while Busy=1 shall be ignored; ClrReq in the DONE cycle shall not restart a clear.
REQ-030 ClrReq and RegWrite in the same IDLE cycle: write takes effect at that edge, clear starts at that edge and later zeroes that register.
REQ-031 Reads during CLEAR return current contents: already-cleared registers read 0, the rest keep their old values.
REQ-032 Index counter width shall cover NUM_REGS-1 without wrap; no write beyond NUM_REGS-1.

Reset
REQ-033 rst=0 shall immediately, without clk, set all registers to 0, FSM to IDLE, index to 0, Busy=0, ClrDone=0.
REQ-034 rst asserted mid-CLEAR shall abort the sequence with no ClrDone pulse; after release, FSM is in IDLE.
REQ-035 Writes coincident with rst=0 shall be lost; first write takes effect at the first rising edge after release.

Verification
REQ-036 Reset then write 0xDEADBEEF to reg 5, read A1=5 next cycle -> R1=0xDEADBEEF; A2=3 -> R2=0.
REQ-037 BYPASS=1: RegWrite=1, WriteReg=7, WriteData=0x12345678, A1=A2=7 same cycle -> R1=R2=0x12345678; BYPASS=0 build -> old value (0).
REQ-038 Fill regs 0..15 with index+1, pulse ClrReq -> Busy high 17 cycles, ClrDone one pulse on cycle 17, all regs read 0; RegWrite to reg 2 at cycle 4 dropped.
REQ-039 NUM_REGS=13, ADDR_W=4: write 0xAA to WriteReg=14 -> no register changes; A1=14 -> R1=0; clear takes 13 CLEAR cycles.
REQ-040 Start clear, assert rst=0 at CLEAR cycle 6 -> all registers 0 immediately, Busy=0, no ClrDone; after release a normal write succeeds.
REQ-041 ClrReq held high through the whole sequence -> exactly one clear and one ClrDone, then new clear starts from IDLE on the following cycle.
